// File: rtl/dmux16_stream_pkg.sv
// dmux16_stream_pkg: shared sizes, lane types and the lane-select decode helper
package dmux16_stream_pkg;
  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int SEL_W = $clog2(LANES);
  typedef logic [SEL_W-1:0] lane_idx_t;
  typedef logic [WIDTH-1:0] word_t;
  // One-hot lane mask for a word; a broadcast targets every lane at once.
  function automatic logic [LANES-1:0] lane_onehot(lane_idx_t sel, logic bcast);
    return bcast ? '1 : LANES'(1) << sel;
  endfunction
endpackage

// File: rtl/dmux16_stream_if.sv
// dmux16_stream_if: input stream plus per-lane output streams of the demux
interface dmux16_stream_if;
  import dmux16_stream_pkg::*;
  word_t              in_data;
  logic               in_valid;
  logic               in_ready;
  lane_idx_t          sel;
  logic               bcast;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]   out_valid;
  logic [LANES-1:0]   out_ready;
  modport master (
    output in_data, in_valid, sel, bcast, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_valid, sel, bcast, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/dmux16_stream_lane.sv
// dmux16_stream_lane: one-entry holding register for a single output lane
module dmux16_stream_lane
  import dmux16_stream_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_load,
  input  word_t i_load_data,
  input  logic  i_out_ready,
  output word_t o_data,
  output logic  o_valid,
  output logic  o_free
);
  word_t r_data;
  logic  r_valid;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_free  = !r_valid | i_out_ready;
  // Load wins over drain so a same-cycle drain and refill keeps the lane valid;
  // a drained word leaves its data in place.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/dmux16_stream.sv
// dmux16_stream: registered 16-bit stream demux steering one input into LANES lanes
module dmux16_stream
  import dmux16_stream_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  dmux16_stream_if.slave   bus,
  output logic             o_proto_err
);
  logic [LANES-1:0] w_dec;
  logic [LANES-1:0] w_free;
  logic [LANES-1:0] w_load;
  logic [LANES-1:0] w_valid;
  word_t            w_data [LANES];
  logic             w_accept;
  logic             w_viol;
  logic             r_pend;
  lane_idx_t        r_sel;
  logic             r_bcast;
  word_t            r_data;
  logic             r_err;
  assign w_dec        = lane_onehot(bus.sel, bus.bcast);
  // Every targeted lane must be free; untargeted lanes are masked out.
  assign bus.in_ready = &(w_free | ~w_dec);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_load       = w_dec & {LANES{w_accept}};
  assign bus.out_valid = w_valid;
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      dmux16_stream_lane u_lane (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load[i]),
        .i_load_data (bus.in_data),
        .i_out_ready (bus.out_ready[i]),
        .o_data      (w_data[i]),
        .o_valid     (w_valid[i]),
        .o_free      (w_free[i])
      );
      assign bus.out_data[i*WIDTH +: WIDTH] = w_data[i];
    end
  endgenerate
  // A word stalled last cycle must reappear unchanged until it is accepted.
  assign w_viol = r_pend & (!bus.in_valid | (bus.sel != r_sel) |
                            (bus.bcast != r_bcast) | (bus.in_data != r_data));
  assign o_proto_err = r_err;
  // Snapshot of a stalled input and the sticky protocol-error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= 1'b0;
      r_sel   <= '0;
      r_bcast <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pend  <= bus.in_valid & !bus.in_ready;
      r_sel   <= bus.sel;
      r_bcast <= bus.bcast;
      r_data  <= bus.in_data;
      r_err   <= r_err | w_viol;
    end
  end
endmodule

// File: tb/tb_dmux16_stream.sv
// tb_dmux16_stream: directed-vector self-checking bench for dmux16_stream
module tb_dmux16_stream;
  import dmux16_stream_pkg::*;
  logic clk;
  logic rst_n;
  logic proto_err;
  int   n_vec;
  int   n_err;
  dmux16_stream_if bus ();
  dmux16_stream dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_proto_err (proto_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic word_t lane(input int i);
    return bus.out_data[i*WIDTH +: WIDTH];
  endfunction
  task automatic send(input lane_idx_t s, input word_t d);
    bus.in_valid = 1'b1;
    bus.bcast    = 1'b0;
    bus.sel      = s;
    bus.in_data  = d;
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.bcast     = 1'b0;
    bus.out_ready = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_valid", 64'(bus.out_valid), 64'h0);
    check("rst_data", 64'(bus.out_data), 64'h0);
    check("rst_err", 64'(proto_err), 64'h0);
    // steering, back-to-back at full rate
    bus.out_ready = 4'hF;
    send(2, 16'hBEEF);
    #1 check("steer_rdy2", 64'(bus.in_ready), 64'h1);
    tick();
    check("steer_v2", 64'(bus.out_valid), 64'h4);
    check("steer_d2", 64'(lane(2)), 64'hBEEF);
    send(0, 16'h1111);
    #1 check("steer_rdy0", 64'(bus.in_ready), 64'h1);
    tick();
    check("steer_v0", 64'(bus.out_valid), 64'h1);
    check("steer_d0", 64'(lane(0)), 64'h1111);
    check("drain_hold2", 64'(lane(2)), 64'hBEEF);
    send(1, 16'h2222);
    #1 check("steer_rdy1", 64'(bus.in_ready), 64'h1);
    tick();
    check("steer_v1", 64'(bus.out_valid), 64'h2);
    check("steer_d1", 64'(lane(1)), 64'h2222);
    send(3, 16'h3333);
    #1 check("steer_rdy3", 64'(bus.in_ready), 64'h1);
    tick();
    check("steer_v3", 64'(bus.out_valid), 64'h8);
    check("steer_d3", 64'(lane(3)), 64'h3333);
    bus.in_valid = 1'b0;
    tick();
    check("steer_empty", 64'(bus.out_valid), 64'h0);
    // backpressure on lane 1 while lane 0 stays open
    bus.out_ready = 4'b1101;
    send(1, 16'h1234);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h5678;
    #1 check("bp_rdy1", 64'(bus.in_ready), 64'h0);
    tick();
    check("bp_v1", 64'(bus.out_valid), 64'h2);
    check("bp_d1", 64'(lane(1)), 64'h1234);
    send(0, 16'h0BAD);
    #1 check("bp_rdy0", 64'(bus.in_ready), 64'h1);
    tick();
    check("bp_v01", 64'(bus.out_valid), 64'h3);
    check("bp_d0", 64'(lane(0)), 64'h0BAD);
    check("bp_d1_keep", 64'(lane(1)), 64'h1234);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'hF;
    tick();
    check("bp_drained", 64'(bus.out_valid), 64'h0);
    // broadcast blocked by a full lane 3, then released
    bus.out_ready = 4'b0111;
    send(3, 16'h7777);
    tick();
    bus.bcast   = 1'b1;
    bus.in_data = 16'h00FF;
    #1 check("bc_rdy_blk", 64'(bus.in_ready), 64'h0);
    tick();
    check("bc_v_blk", 64'(bus.out_valid), 64'h8);
    check("bc_d3_blk", 64'(lane(3)), 64'h7777);
    bus.out_ready = 4'hF;
    #1 check("bc_rdy_go", 64'(bus.in_ready), 64'h1);
    tick();
    check("bc_v", 64'(bus.out_valid), 64'hF);
    check("bc_d", 64'(bus.out_data), 64'h00FF_00FF_00FF_00FF);
    check("bc_err", 64'(proto_err), 64'h0);
    bus.in_valid = 1'b0;
    bus.bcast    = 1'b0;
    tick();
    // drain and refill lane 0 in one cycle
    send(0, 16'h0001);
    tick();
    send(0, 16'hA5A5);
    #1 check("dr_rdy", 64'(bus.in_ready), 64'h1);
    tick();
    check("dr_v", 64'(bus.out_valid), 64'h1);
    check("dr_d", 64'(lane(0)), 64'hA5A5);
    bus.in_valid = 1'b0;
    tick();
    check("dr_empty", 64'(bus.out_valid), 64'h0);
    // protocol violation: retarget a stalled word
    bus.out_ready = 4'b1101;
    send(1, 16'h4444);
    tick();
    bus.in_data = 16'h5555;
    #1 check("pe_rdy", 64'(bus.in_ready), 64'h0);
    tick();
    check("pe_hold_ok", 64'(proto_err), 64'h0);
    bus.sel = 2;
    tick();
    check("pe_set", 64'(proto_err), 64'h1);
    check("pe_v2", 64'(bus.out_valid[2]), 64'h1);
    check("pe_d2", 64'(lane(2)), 64'h5555);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'hF;
    repeat (2) tick();
    check("pe_sticky", 64'(proto_err), 64'h1);
    // async reset mid-stream with lanes 1 and 3 holding words
    bus.out_ready = 4'h0;
    send(1, 16'hC001);
    tick();
    send(3, 16'hC003);
    tick();
    bus.in_valid = 1'b0;
    check("mr_v_pre", 64'(bus.out_valid), 64'hA);
    #2 rst_n = 1'b0;
    #1;
    check("mr_v", 64'(bus.out_valid), 64'h0);
    check("mr_d", 64'(bus.out_data), 64'h0);
    check("mr_err", 64'(proto_err), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_post_v", 64'(bus.out_valid), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
